// File: rtl/dec_pkg.sv
// dec_pkg: shared mode constants and helpers for the scanning one-hot decoder
package dec_pkg;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  function automatic int clog2(input int v);
    for (int r = 0; r < 32; r++) if ((1 << r) >= v) return r;
    return 32;
  endfunction
  function automatic logic [255:0] onehot(input int unsigned i);
    return 256'(1) << i;
  endfunction
endpackage

// File: rtl/dec_prescaler.sv
// dec_prescaler: DIV-cycle step counter with enable/clear (ports: clk, rst, en, clr -> step)
module dec_prescaler
  import dec_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);
  localparam int W = clog2(DIV) > 1 ? clog2(DIV) : 1;
  logic [W-1:0] pc;
  assign step = en && !clr && pc == W'(DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= '0;
    else if (en) pc <= (clr || step) ? '0 : pc + W'(1);
endmodule

// File: rtl/dec_scan_nxm.sv
// dec_scan_nxm: registered N->2^N decoder with auto-scan (ports: SYSCLK, SYSRESET, en, mode, sel, limit -> y, y_idx, wrap; DEC_OUT_ACTIVE_LOW_EN makes y one-cold)
module dec_scan_nxm
  import dec_pkg::*;
#(
  parameter int N = 2,
  parameter int DIV = 4
) (
  input  logic              SYSCLK,
  input  logic              SYSRESET,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      sel,
  input  logic [N-1:0]      limit,
  output logic [(2**N)-1:0] y,
  output logic [N-1:0]      y_idx,
  output logic              wrap
);
  localparam int M = 2 ** N;
`ifdef DEC_OUT_ACTIVE_LOW_EN
  localparam logic [M-1:0] POL = '1;
`else
  localparam logic [M-1:0] POL = '0;
`endif
  logic step, at_lim;
  logic [N-1:0] nidx;
  dec_prescaler #(.DIV(DIV)) u_pre (
    .clk(SYSCLK), .rst(SYSRESET), .en(en), .clr(mode == MODE_DIRECT), .step(step)
  );
  always_comb begin
    at_lim = y_idx >= limit;
    nidx = mode == MODE_DIRECT ? sel : !step ? y_idx : at_lim ? '0 : y_idx + N'(1);
  end
  always_ff @(posedge SYSCLK or posedge SYSRESET)
    if (SYSRESET) begin
      y <= POL;
      y_idx <= '0;
      wrap <= 1'b0;
    end else if (!en) begin
      y <= POL;
      wrap <= 1'b0;
    end else begin
      y <= M'(onehot(32'(nidx))) ^ POL;
      y_idx <= nidx;
      wrap <= step && at_lim;
    end
endmodule

// File: doc/dec_scan_nxm.md
Name: dec_scan_nxm

Overview:
- Parametrised, registered successor to the combinational 2x4 decoder with enable.
- Decodes an N-bit select into a 2^N one-hot output vector.
- Adds an auto-scan mode: an internal prescaled counter walks the one-hot output through positions 0..limit.
- Sits in front of multiplexed displays, row/column strobes and chip-select banks; `y` drives loads directly from flops.

Parameters:
- N, 2: select width; output width is 2^N (N >= 1).
- DIV, 4: scan step period in SYSCLK cycles (DIV >= 1).

Ports:
- SYSCLK  in  1  system clock, rising edge.
- SYSRESET  in  1  asynchronous, active-high reset.
- en  in  1  enable. 0 forces outputs off and freezes scan state.
- mode  in  1  0 = direct decode, 1 = auto-scan.
- sel  in  N  decode select (mode 0).
- limit  in  N  highest scan index (mode 1).
- y  out  2^N  registered one-hot decoder output.
- y_idx  out  N  registered binary index of the active output.
- wrap  out  1  one-cycle pulse when the scan index returns to 0.

Behaviour:
- Reset (async, active-high):
  - y=0, y_idx=0, wrap=0.
  - Prescaler count pc=0.
  - All registers update only on the SYSCLK rising edge otherwise.
- Reset asserted mid-scan: outputs clear immediately (asynchronously). After release, scanning restarts from idx 0 with pc 0.
- en=0:
  - Next edge: y=0, wrap=0.
  - y_idx and pc hold their values. The scan resumes where it stopped once en returns to 1.
- en=1, mode=0 (direct), latency 1 cycle:
  - y <= 1<<sel, y_idx <= sel, pc <= 0, wrap <= 0.
  - sel changes are tracked every cycle.
- en=1, mode=1 (scan):
  - pc counts 0..DIV-1, then back to 0.
  - When pc==DIV-1 (a step):
    - If y_idx >= limit: y_idx <= 0 and wrap <= 1.
    - Otherwise: y_idx <= y_idx+1.
  - wrap=0 on every non-step cycle.
  - y is always the one-hot of the registered y_idx, updated in the same edge as y_idx. y and y_idx never disagree.
- Boundaries:
  - limit=0: idx stays 0; wrap pulses every DIV cycles.
  - limit lowered below the current idx: the next step goes to 0 with wrap.
  - limit=2^N-1: natural full wrap, no overflow beyond N bits.
  - DIV=1: a step on every enabled cycle.
  - pc width is max(1, clog2(DIV)).
- Mode switch:
  - 0->1: scanning starts from the last decoded sel with pc already 0. The first step comes DIV cycles later.
  - 1->0: the next edge follows sel immediately.
- Arithmetic: all index arithmetic is unsigned N bits. Comparison against limit is unsigned.

Optional Feature:
- Macro: DEC_OUT_ACTIVE_LOW_EN.
- Defined:
  - y is driven inverted (one-cold, active-low, 74x139 style).
  - Reset and en=0 drive y to all ones.
  - y_idx and wrap are unchanged.
- Undefined: active-high one-hot as described above; off state is all zeros.

Decomposition:
- Shared package dec_pkg:
  - MODE_DIRECT=1'b0, MODE_SCAN=1'b1 constants.
  - onehot(N) function.
  - clog2 helper for the pc width.
- One natural sub-module, dec_prescaler:
  - DIV-parameterised counter with enable, clear and step output.
  - Instantiated once; the rest stays in the top.

Test Plan:
All scenarios use N=2, DIV=4.
- Direct decode: reset, en=1, mode=0, sel=0,1,2,3 on consecutive cycles -> y=0001,0010,0100,1000, each one cycle after its sel; y_idx matches; wrap=0.
- Enable gating: en=0 with sel=2 -> y=0000 next edge. Re-enable -> y=0100 one cycle later.
- Full scan: mode=1, limit=3 from idx 0 -> y steps every 4 cycles 0001,0010,0100,1000,0001. wrap is high for exactly 1 cycle, coincident with y_idx=0 after 3.
- Short scan:
  - limit=1 -> idx sequence 0,1,0,1 with wrap every 8 cycles.
  - Lower limit to 0 while idx=1 -> next step goes to 0 with wrap.
- Freeze and reset:
  - en=0 for 10 cycles during scan at idx=2, pc=1 -> on re-enable the step to 3 occurs 2 cycles later.
  - Async SYSRESET pulse mid-cycle -> y=0000 and y_idx=0 before the next edge.
- Macro build with DEC_OUT_ACTIVE_LOW_EN: rerun direct decode -> y=1110,1101,1011,0111. Reset and en=0 -> y=1111.
